// File: rtl/seg_scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux
//  Purpose  : Time-multiplexed scanner for a NUM_DIGITS common-anode 7-segment
//             display. A packed hex word is accepted over a valid/ready
//             handshake into a pending register, promoted to the display
//             shadow register only at a frame boundary (no tearing), and the
//             digits are scanned one slot at a time with an all-anodes-off
//             guard interval at the start of every slot (no ghosting).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1              system clock, rising edge
//    rst_n        in   1              asynchronous reset, active-low
//    load_valid   in   1              data_in valid
//    load_ready   out  1              block can accept data_in
//    data_in      in   NUM_DIGITS*WL  packed digits, digit i = data_in[i*WL +: WL]
//    blank_mask   in   NUM_DIGITS     1 = digit i never lit (sampled live)
//    value        out  WL             nibble of the current digit, to decoder
//    an           out  NUM_DIGITS     anode enables, active-low
//    frame_start  out  1              pulse on the first cycle of the digit-0 slot
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_DIGITS   digits scanned; digit 0 = LS nibble = rightmost anode
//    WL           nibble width, matches the decoder input
//    REFRESH_DIV  clk cycles per digit slot (>= GUARD_CYC+1)
//    GUARD_CYC    cycles at slot start with all anodes off (>= 1)
// ============================================================================
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int WL          = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [NUM_DIGITS*WL-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]    blank_mask,
  output logic [WL-1:0]            value,
  output logic [NUM_DIGITS-1:0]    an,
  output logic                     frame_start
);

  localparam int DATA_W = NUM_DIGITS * WL;
  localparam int DW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW     = $clog2(REFRESH_DIV + 1);

  localparam logic [CW-1:0] C_SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [DW-1:0] C_DIG_LAST   = DW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Scan position registers.
  // r_slot_cnt / r_dig_idx / r_state describe the scan position of the cycle
  // whose outputs are being computed now and will appear after the next edge.
  // Because every output is registered, this keeps the outputs aligned with
  // the position: the reset state is "next cycle is the start of the digit-0
  // slot", so the first cycle after reset release carries frame_start.
  // --------------------------------------------------------------------------
  logic [CW-1:0]     r_slot_cnt;
  logic [DW-1:0]     r_dig_idx;
  state_t            r_state;

  // Data path registers
  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_pending;
  logic              r_pend_flag;
  logic              r_applied;   // shadow was loaded on the current cycle

  // Output registers
  logic              r_load_ready;
  logic [NUM_DIGITS-1:0] r_an;
  logic [WL-1:0]     r_value;
  logic              r_frame_start;

  // Combinational helpers
  logic              w_accept;
  logic              w_pend_in;
  logic [DATA_W-1:0] w_pending_in;
  logic              w_frame_next;
  logic              w_apply;
  logic [DATA_W-1:0] w_shadow_in;
  logic              w_pend_next;
  logic              w_slot_last;
  logic              w_dig_last;
  logic [NUM_DIGITS-1:0] w_an_drive;

  assign w_accept    = load_valid && r_load_ready;

  // Pending state as it stands at the end of this cycle, including a capture
  // happening right now. A word accepted on the last cycle of a frame is
  // therefore already pending when the boundary cycle begins and is shown
  // from that boundary on.
  assign w_pend_in    = w_accept | r_pend_flag;
  assign w_pending_in = w_accept ? data_in : r_pending;

  assign w_slot_last  = (r_slot_cnt == C_SLOT_LAST);
  assign w_dig_last   = (r_dig_idx == C_DIG_LAST);

  // The cycle being prepared is the first cycle of the digit-0 slot
  assign w_frame_next = (r_slot_cnt == '0) && (r_dig_idx == '0);

  // Promote pending -> shadow only at a frame boundary
  assign w_apply      = w_frame_next && w_pend_in;
  assign w_shadow_in  = w_apply ? w_pending_in : r_shadow;

  // The pend flag stays set through the boundary cycle itself (no capture can
  // occur there) and drops one cycle later, so load_ready returns the cycle
  // after frame_start. A capture on the boundary cycle is therefore only
  // possible when nothing was pending, and it waits for the next boundary.
  assign w_pend_next  = r_applied ? 1'b0 : w_pend_in;

  // Anode pattern while driving: only the current digit low, unless blanked
  always_comb begin
    w_an_drive = '1;
    if (!blank_mask[r_dig_idx]) begin
      w_an_drive[r_dig_idx] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Slot FSM, scan counters, handshake and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt    <= '0;
      r_dig_idx     <= '0;
      r_state       <= ST_GUARD;
      r_shadow      <= '0;
      r_pending     <= '0;
      r_pend_flag   <= 1'b0;
      r_applied     <= 1'b0;
      r_load_ready  <= 1'b1;
      r_an          <= '1;
      r_value       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      // Slot counter wraps every REFRESH_DIV cycles; digit advances on wrap
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        r_dig_idx  <= w_dig_last ? '0 : r_dig_idx + 1'b1;
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
      end

      // Guard / drive sequencing within a slot
      case (r_state)
        ST_GUARD: begin
          if (r_slot_cnt == C_GUARD_LAST) begin
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (w_slot_last) begin
            r_state <= ST_GUARD;
          end
        end
        default: r_state <= ST_GUARD;
      endcase

      // Registered outputs for the position described by the scan registers
      r_an          <= (r_state == ST_DRIVE) ? w_an_drive : '1;
      r_value       <= w_shadow_in[r_dig_idx*WL +: WL];
      r_frame_start <= w_frame_next;

      // Handshake and double buffer
      r_pending     <= w_pending_in;
      r_shadow      <= w_shadow_in;
      r_applied     <= w_apply;
      r_pend_flag   <= w_pend_next;
      r_load_ready  <= ~w_pend_next;
    end
  end

  assign load_ready  = r_load_ready;
  assign an          = r_an;
  assign value       = r_value;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire
